// File: rtl/mc_ctrl_if.sv
// Control bus between the multi-cycle control unit and the datapath.
// The master side is the control unit; the slave side is the datapath/IR/memory.
// Parameter CNT_W must match the control unit's retired-counter width.
interface mc_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic [2:0]       state;
    logic             pc_we;
    logic [1:0]       pc_sel;
    logic             ir_we;
    logic             mem_rd;
    logic             mem_wr;
    logic             reg_we;
    logic [1:0]       reg_dst;
    logic [1:0]       wb_sel;
    logic             alu_src;
    logic [1:0]       alu_op;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        input  op, funct, zero, mem_ready,
        output state, pc_we, pc_sel, ir_we, mem_rd, mem_wr, reg_we,
               reg_dst, wb_sel, alu_src, alu_op, illegal, retired
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  state, pc_we, pc_sel, ir_we, mem_rd, mem_wr, reg_we,
               reg_dst, wb_sel, alu_src, alu_op, illegal, retired
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control FSM: FETCH/DECODE/EXEC/MEM/WB plus sticky TRAP.
// Strobes are combinational from state/op/funct/zero/mem_ready; state and retired count registered.
// FETCH and MEM hold (strobes asserted, no advance) while mem_ready is low when MEM_WAIT=1.
module mc_ctrl #(
    parameter int MEM_WAIT = 1,
    parameter int CNT_W    = 16,
    parameter int EN_J     = 1
) (
    input  logic     clk,
    input  logic     reset,
    mc_ctrl_if.master bus
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [CNT_W-1:0] r_retired;

    logic w_rdy;
    logic w_rtype, w_addu, w_subu, w_jr, w_ori, w_lw, w_sw, w_beq, w_lui, w_jal, w_j;
    logic w_legal;

    logic       w_pc_we, w_ir_we, w_mem_rd, w_mem_wr, w_reg_we, w_alu_src;
    logic [1:0] w_pc_sel, w_reg_dst, w_wb_sel, w_alu_op;

    // With MEM_WAIT=0 the memory is assumed to always complete in one cycle.
    assign w_rdy = (MEM_WAIT == 0) ? 1'b1 : bus.mem_ready;

    assign w_rtype = (bus.op == 6'b000000);
    assign w_addu  = w_rtype && (bus.funct == 6'b100001);
    assign w_subu  = w_rtype && (bus.funct == 6'b100011);
    assign w_jr    = w_rtype && (bus.funct == 6'b001000);
    assign w_ori   = (bus.op == 6'b001101);
    assign w_lw    = (bus.op == 6'b100011);
    assign w_sw    = (bus.op == 6'b101011);
    assign w_beq   = (bus.op == 6'b000100);
    assign w_lui   = (bus.op == 6'b001111);
    assign w_jal   = (bus.op == 6'b000011);
    assign w_j     = (EN_J != 0) && (bus.op == 6'b000010);
    assign w_legal = w_addu || w_subu || w_jr || w_ori || w_lw || w_sw ||
                     w_beq || w_lui || w_jal || w_j;

    // Next-state selection and per-state datapath strobes.
    always_comb begin
        w_next    = r_state;
        w_pc_we   = 1'b0;
        w_pc_sel  = 2'b00;
        w_ir_we   = 1'b0;
        w_mem_rd  = 1'b0;
        w_mem_wr  = 1'b0;
        w_reg_we  = 1'b0;
        w_reg_dst = 2'b00;
        w_wb_sel  = 2'b00;
        w_alu_src = 1'b0;
        w_alu_op  = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_mem_rd = 1'b1;
                if (w_rdy) begin
                    w_ir_we = 1'b1;
                    w_pc_we = 1'b1;
                    w_next  = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!w_legal) begin
                    w_next = S_TRAP;
                end else if (w_j) begin
                    w_pc_we  = 1'b1;
                    w_pc_sel = 2'b10;
                    w_next   = S_FETCH;
                end else if (w_jal) begin
                    w_next = S_WB;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_next = S_WB;
                if (w_subu) begin
                    w_alu_op = 2'b01;
                end else if (w_ori) begin
                    w_alu_op  = 2'b10;
                    w_alu_src = 1'b1;
                end else if (w_lui) begin
                    w_alu_op  = 2'b11;
                    w_alu_src = 1'b1;
                end else if (w_lw || w_sw) begin
                    w_alu_src = 1'b1;
                    w_next    = S_MEM;
                end else if (w_beq) begin
                    w_alu_op = 2'b01;
                    w_pc_we  = bus.zero;
                    w_pc_sel = 2'b01;
                    w_next   = S_FETCH;
                end else if (w_jr) begin
                    w_pc_we  = 1'b1;
                    w_pc_sel = 2'b11;
                    w_next   = S_FETCH;
                end
            end
            S_MEM: begin
                // Request stays asserted across the stall; the access lands in the ready cycle.
                w_mem_rd = w_lw;
                w_mem_wr = w_sw;
                if (w_rdy) begin
                    w_next = w_lw ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                w_reg_we = 1'b1;
                w_next   = S_FETCH;
                if (w_ori || w_lui) begin
                    w_reg_dst = 2'b01;
                end else if (w_lw) begin
                    w_reg_dst = 2'b01;
                    w_wb_sel  = 2'b01;
                end else if (w_jal) begin
                    w_reg_dst = 2'b10;
                    w_wb_sel  = 2'b10;
                    w_pc_we   = 1'b1;
                    w_pc_sel  = 2'b10;
                end
            end
            S_TRAP: begin
                w_next = S_TRAP;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
        // Nothing may write PC/IR/regs/memory while reset is held.
        if (reset) begin
            w_pc_we   = 1'b0;
            w_pc_sel  = 2'b00;
            w_ir_we   = 1'b0;
            w_mem_rd  = 1'b0;
            w_mem_wr  = 1'b0;
            w_reg_we  = 1'b0;
            w_reg_dst = 2'b00;
            w_wb_sel  = 2'b00;
            w_alu_src = 1'b0;
            w_alu_op  = 2'b00;
        end
    end

    // State register; reset wins over TRAP and any stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Retire count: one per return to FETCH from an instruction state, wrapping freely.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_retired <= '0;
        end else if ((w_next == S_FETCH) && (r_state != S_FETCH) && (r_state != S_TRAP)) begin
            r_retired <= r_retired + 1'b1;
        end
    end

    assign bus.state   = r_state;
    assign bus.pc_we   = w_pc_we;
    assign bus.pc_sel  = w_pc_sel;
    assign bus.ir_we   = w_ir_we;
    assign bus.mem_rd  = w_mem_rd;
    assign bus.mem_wr  = w_mem_wr;
    assign bus.reg_we  = w_reg_we;
    assign bus.reg_dst = w_reg_dst;
    assign bus.wb_sel  = w_wb_sel;
    assign bus.alu_src = w_alu_src;
    assign bus.alu_op  = w_alu_op;
    assign bus.illegal = (r_state == S_TRAP);
    assign bus.retired = r_retired;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: three instances (default, CNT_W=4, EN_J=0) share one stimulus.
// Outputs are sampled on the falling edge, inputs change there too.
// Instances diverge only on j, where the EN_J=0 copy traps.
module tb_mc_ctrl;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    int checks = 0;
    int passes = 0;

    mc_ctrl_if #(.CNT_W(16)) if1 ();
    mc_ctrl_if #(.CNT_W(4))  if2 ();
    mc_ctrl_if #(.CNT_W(16)) if3 ();

    assign if1.op = op;  assign if1.funct = funct;  assign if1.zero = zero;  assign if1.mem_ready = mem_ready;
    assign if2.op = op;  assign if2.funct = funct;  assign if2.zero = zero;  assign if2.mem_ready = mem_ready;
    assign if3.op = op;  assign if3.funct = funct;  assign if3.zero = zero;  assign if3.mem_ready = mem_ready;

    mc_ctrl #(.MEM_WAIT(1), .CNT_W(16), .EN_J(1)) u_dut  (.clk(clk), .reset(reset), .bus(if1.master));
    mc_ctrl #(.MEM_WAIT(1), .CNT_W(4),  .EN_J(1)) u_dut4 (.clk(clk), .reset(reset), .bus(if2.master));
    mc_ctrl #(.MEM_WAIT(1), .CNT_W(16), .EN_J(0)) u_dutj (.clk(clk), .reset(reset), .bus(if3.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {state, pc_we, pc_sel, ir_we, mem_rd, mem_wr, reg_we, reg_dst, wb_sel, alu_src, alu_op}
    logic [16:0] obs1;
    assign obs1 = {if1.state, if1.pc_we, if1.pc_sel, if1.ir_we, if1.mem_rd, if1.mem_wr,
                   if1.reg_we, if1.reg_dst, if1.wb_sel, if1.alu_src, if1.alu_op};
    logic [4:0] stb1;
    assign stb1 = {if1.pc_we, if1.ir_we, if1.mem_rd, if1.mem_wr, if1.reg_we};

    function automatic logic [16:0] mk_row(input logic [2:0] st, input logic pcwe, input logic [1:0] pcsel,
                                           input logic irwe, input logic mrd, input logic mwr, input logic rwe,
                                           input logic [1:0] rdst, input logic [1:0] wb, input logic asrc,
                                           input logic [1:0] aop);
        return {st, pcwe, pcsel, irwe, mrd, mwr, rwe, rdst, wb, asrc, aop};
    endfunction

    logic [16:0] rows [0:8][0:4];
    logic [5:0]  seq_op    [0:8];
    logic [5:0]  seq_funct [0:8];
    logic        seq_zero  [0:8];
    int          seq_len   [0:8];

    task automatic test_reset();
        reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        #1;
        checks++;
        if (stb1 !== 5'b0) $display("FAIL reset_strobes got=%b exp=%b", stb1, 5'b0); else passes++;
        checks++;
        if (if1.state !== 3'd0) $display("FAIL reset_state got=%0d exp=0", if1.state); else passes++;
        checks++;
        if (if1.retired !== 16'd0) $display("FAIL reset_retired got=%0d exp=0", if1.retired); else passes++;
        checks++;
        if (if1.illegal !== 1'b0) $display("FAIL reset_illegal got=%b exp=0", if1.illegal); else passes++;
        reset = 1'b0;
        #1;
        checks++;
        if (obs1 !== mk_row(0,1,0,1,1,0,0,0,0,0,0)) $display("FAIL fetch_after_reset got=%h exp=%h", obs1, mk_row(0,1,0,1,1,0,0,0,0,0,0)); else passes++;
    endtask

    task automatic test_sequence();
        logic [16:0] f, d;
        f = mk_row(0,1,0,1,1,0,0,0,0,0,0);
        d = mk_row(1,0,0,0,0,0,0,0,0,0,0);
        // addu
        seq_op[0] = 6'b000000; seq_funct[0] = 6'b100001; seq_zero[0] = 0; seq_len[0] = 4;
        rows[0][0] = f; rows[0][1] = d; rows[0][2] = mk_row(2,0,0,0,0,0,0,0,0,0,0); rows[0][3] = mk_row(4,0,0,0,0,0,1,0,0,0,0); rows[0][4] = '0;
        // subu
        seq_op[1] = 6'b000000; seq_funct[1] = 6'b100011; seq_zero[1] = 0; seq_len[1] = 4;
        rows[1][0] = f; rows[1][1] = d; rows[1][2] = mk_row(2,0,0,0,0,0,0,0,0,0,1); rows[1][3] = mk_row(4,0,0,0,0,0,1,0,0,0,0); rows[1][4] = '0;
        // ori
        seq_op[2] = 6'b001101; seq_funct[2] = 6'b000000; seq_zero[2] = 0; seq_len[2] = 4;
        rows[2][0] = f; rows[2][1] = d; rows[2][2] = mk_row(2,0,0,0,0,0,0,0,0,1,2); rows[2][3] = mk_row(4,0,0,0,0,0,1,1,0,0,0); rows[2][4] = '0;
        // lw
        seq_op[3] = 6'b100011; seq_funct[3] = 6'b000000; seq_zero[3] = 0; seq_len[3] = 5;
        rows[3][0] = f; rows[3][1] = d; rows[3][2] = mk_row(2,0,0,0,0,0,0,0,0,1,0); rows[3][3] = mk_row(3,0,0,0,1,0,0,0,0,0,0); rows[3][4] = mk_row(4,0,0,0,0,0,1,1,1,0,0);
        // sw
        seq_op[4] = 6'b101011; seq_funct[4] = 6'b000000; seq_zero[4] = 0; seq_len[4] = 4;
        rows[4][0] = f; rows[4][1] = d; rows[4][2] = mk_row(2,0,0,0,0,0,0,0,0,1,0); rows[4][3] = mk_row(3,0,0,0,0,1,0,0,0,0,0); rows[4][4] = '0;
        // beq taken
        seq_op[5] = 6'b000100; seq_funct[5] = 6'b000000; seq_zero[5] = 1; seq_len[5] = 3;
        rows[5][0] = f; rows[5][1] = d; rows[5][2] = mk_row(2,1,1,0,0,0,0,0,0,0,1); rows[5][3] = '0; rows[5][4] = '0;
        // lui
        seq_op[6] = 6'b001111; seq_funct[6] = 6'b000000; seq_zero[6] = 0; seq_len[6] = 4;
        rows[6][0] = f; rows[6][1] = d; rows[6][2] = mk_row(2,0,0,0,0,0,0,0,0,1,3); rows[6][3] = mk_row(4,0,0,0,0,0,1,1,0,0,0); rows[6][4] = '0;
        // jal
        seq_op[7] = 6'b000011; seq_funct[7] = 6'b000000; seq_zero[7] = 0; seq_len[7] = 3;
        rows[7][0] = f; rows[7][1] = d; rows[7][2] = mk_row(4,1,2,0,0,0,1,2,2,0,0); rows[7][3] = '0; rows[7][4] = '0;
        // jr
        seq_op[8] = 6'b000000; seq_funct[8] = 6'b001000; seq_zero[8] = 0; seq_len[8] = 3;
        rows[8][0] = f; rows[8][1] = d; rows[8][2] = mk_row(2,1,3,0,0,0,0,0,0,0,0); rows[8][3] = '0; rows[8][4] = '0;

        for (int i = 0; i < 9; i++) begin
            op = seq_op[i]; funct = seq_funct[i]; zero = seq_zero[i];
            for (int c = 0; c < seq_len[i]; c++) begin
                #1;
                checks++;
                if (obs1 !== rows[i][c]) $display("FAIL seq%0d_cyc%0d got=%h exp=%h", i, c, obs1, rows[i][c]); else passes++;
                @(negedge clk);
            end
            #1;
            checks++;
            if (if1.state !== 3'd0) $display("FAIL seq%0d_len got_state=%0d exp=0", i, if1.state); else passes++;
            checks++;
            if (if1.retired !== 16'(i + 1)) $display("FAIL seq%0d_retired got=%0d exp=%0d", i, if1.retired, i + 1); else passes++;
        end
    endtask

    task automatic test_beq_not_taken();
        op = 6'b000100; funct = 6'd0; zero = 1'b0;
        @(negedge clk); @(negedge clk);
        #1;
        checks++;
        if (obs1 !== mk_row(2,0,1,0,0,0,0,0,0,0,1)) $display("FAIL beq_nt_exec got=%h exp=%h", obs1, mk_row(2,0,1,0,0,0,0,0,0,0,1)); else passes++;
        @(negedge clk);
        #1;
        checks++;
        if (if1.state !== 3'd0) $display("FAIL beq_nt_len got_state=%0d exp=0", if1.state); else passes++;
        checks++;
        if (if1.retired !== 16'd10) $display("FAIL beq_nt_retired got=%0d exp=10", if1.retired); else passes++;
    endtask

    task automatic test_stall_lw();
        logic [2:0] exp_st [0:9];
        exp_st[0] = 0; exp_st[1] = 0; exp_st[2] = 0; exp_st[3] = 0; exp_st[4] = 1;
        exp_st[5] = 2; exp_st[6] = 3; exp_st[7] = 3; exp_st[8] = 3; exp_st[9] = 4;
        op = 6'b100011; funct = 6'd0; zero = 1'b0;
        for (int k = 0; k < 10; k++) begin
            mem_ready = !((k < 3) || (k == 6) || (k == 7));
            #1;
            checks++;
            if (if1.state !== exp_st[k]) $display("FAIL stall_state_k%0d got=%0d exp=%0d", k, if1.state, exp_st[k]); else passes++;
            checks++;
            if (if1.mem_rd !== ((exp_st[k] == 3'd0) || (exp_st[k] == 3'd3))) $display("FAIL stall_mem_rd_k%0d got=%b", k, if1.mem_rd); else passes++;
            checks++;
            if (if1.ir_we !== (k == 3)) $display("FAIL stall_ir_we_k%0d got=%b exp=%b", k, if1.ir_we, (k == 3)); else passes++;
            checks++;
            if (if1.reg_we !== (k == 9)) $display("FAIL stall_reg_we_k%0d got=%b exp=%b", k, if1.reg_we, (k == 9)); else passes++;
            if (k == 9) begin
                checks++;
                if (if1.wb_sel !== 2'b01) $display("FAIL stall_wb_sel got=%b exp=01", if1.wb_sel); else passes++;
            end
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (if1.state !== 3'd0) $display("FAIL stall_len got_state=%0d exp=0", if1.state); else passes++;
        checks++;
        if (if1.retired !== 16'd11) $display("FAIL stall_retired got=%0d exp=11", if1.retired); else passes++;
    endtask

    task automatic test_illegal(input logic [5:0] t_op, input logic [5:0] t_funct, input logic [15:0] exp_ret);
        op = t_op; funct = t_funct; zero = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (obs1 !== mk_row(1,0,0,0,0,0,0,0,0,0,0)) $display("FAIL ill_decode_%b got=%h", t_op, obs1); else passes++;
        @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            #1;
            checks++;
            if ({if1.state, if1.illegal, stb1} !== {3'd5, 1'b1, 5'b0})
                $display("FAIL ill_trap_%b_k%0d got_state=%0d illegal=%b strobes=%b", t_op, k, if1.state, if1.illegal, stb1);
            else passes++;
            checks++;
            if (if1.retired !== exp_ret) $display("FAIL ill_retired_k%0d got=%0d exp=%0d", k, if1.retired, exp_ret); else passes++;
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({if1.state, if1.illegal} !== {3'd0, 1'b0}) $display("FAIL ill_reset got_state=%0d illegal=%b exp=0/0", if1.state, if1.illegal); else passes++;
        reset = 1'b0;
    endtask

    task automatic test_wrap();
        int cyc;
        int timeouts;
        timeouts = 0;
        reset = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        op = 6'b000000; funct = 6'b100001;
        for (int n = 0; n < 17; n++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while ((if1.state != 3'd0) && (cyc < 10));
            if (cyc >= 10) timeouts++;
        end
        #1;
        checks++;
        if (timeouts !== 0) $display("FAIL wrap_timeout got=%0d exp=0", timeouts); else passes++;
        checks++;
        if (if2.retired !== 4'd1) $display("FAIL wrap_cnt4 got=%0d exp=1", if2.retired); else passes++;
        checks++;
        if (if1.retired !== 16'd17) $display("FAIL wrap_cnt16 got=%0d exp=17", if1.retired); else passes++;
        op = 6'b100011; funct = 6'd0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({if2.state, if2.mem_rd} !== {3'd3, 1'b1}) $display("FAIL wrap_mem_stall got_state=%0d mem_rd=%b", if2.state, if2.mem_rd); else passes++;
        reset = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({if2.state, if2.retired} !== {3'd0, 4'd0}) $display("FAIL wrap_reset got_state=%0d retired=%0d exp=0/0", if2.state, if2.retired); else passes++;
        reset = 1'b0;
        mem_ready = 1'b1;
    endtask

    task automatic test_j();
        op = 6'b000010; funct = 6'd0;
        @(negedge clk);
        #1;
        checks++;
        if ({if1.state, if1.pc_we, if1.pc_sel} !== {3'd1, 1'b1, 2'b10}) $display("FAIL j_decode got_state=%0d pc_we=%b pc_sel=%b", if1.state, if1.pc_we, if1.pc_sel); else passes++;
        checks++;
        if (if3.pc_we !== 1'b0) $display("FAIL j_off_decode got_pc_we=%b exp=0", if3.pc_we); else passes++;
        @(negedge clk);
        #1;
        checks++;
        if ({if1.state, if1.retired} !== {3'd0, 16'd1}) $display("FAIL j_len got_state=%0d retired=%0d exp=0/1", if1.state, if1.retired); else passes++;
        checks++;
        if ({if3.state, if3.illegal} !== {3'd5, 1'b1}) $display("FAIL j_off_trap got_state=%0d illegal=%b exp=5/1", if3.state, if3.illegal); else passes++;
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_beq_not_taken();
        test_stall_lw();
        test_illegal(6'b111111, 6'b000000, 16'd11);
        test_illegal(6'b000000, 6'b000000, 16'd0);
        test_wrap();
        test_j();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control unit for the MIPS-subset CPU. Successor to the single-cycle combinational AND/OR-plane decoder.
- Decodes op/funct once per instruction and walks a FETCH/DECODE/EXEC/MEM/WB state machine. Issues per-state datapath strobes.
- Stalls on a memory ready handshake, traps illegal encodings and counts retired instructions.
- Sits between the instruction register and the datapath; all sequencing of PC, IR, register file and data memory originates here.

Parameters:
- MEM_WAIT, 1: 1 means FETCH and MEM stall until mem_ready; 0 means mem_ready is ignored and treated as 1.
- CNT_W, 16: width of the retired-instruction counter.
- EN_J, 1: 1 decodes j (op 000010); 0 treats j as illegal.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- op  in  6  instr[31:26] from the IR; stable from DECODE onward.
- funct  in  6  instr[5:0] from the IR.
- zero  in  1  ALU zero flag; sampled in EXEC for beq.
- mem_ready  in  1  memory handshake; access completes in the cycle it is 1.
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- pc_we  out  1  PC write strobe.
- pc_sel  out  2  PC source: 00 pc+4, 01 branch target, 10 jump target, 11 rs.
- ir_we  out  1  IR write strobe.
- mem_rd  out  1  memory read request.
- mem_wr  out  1  memory write request.
- reg_we  out  1  register file write strobe.
- reg_dst  out  2  destination register: 00 rd, 01 rt, 10 $31.
- wb_sel  out  2  writeback source: 00 ALU, 01 memory, 10 pc+4.
- alu_src  out  1  0 selects rt; 1 selects the immediate.
- alu_op  out  2  00 add, 01 sub, 10 or, 11 lui (imm<<16).
- illegal  out  1  sticky trap flag.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset (synchronous, active-high, on the clk edge):
  - state=FETCH, retired=0, illegal=0.
  - All strobes 0 in the reset cycle.
  - Reset overrides any state, including TRAP and mid-stall.
- Outputs are combinational from state, op, funct, zero and mem_ready. State and counter are registered.
- Decoding:
  - R-type is op=000000 with funct addu=100001, subu=100011, jr=001000.
  - I/J-type ops: ori=001101, lw=100011, sw=101011, beq=000100, lui=001111, jal=000011, j=000010.
- FETCH:
  - mem_rd=1 throughout.
  - While mem_ready=0 (and MEM_WAIT=1): stay in FETCH with ir_we=0 and pc_we=0.
  - In the mem_ready=1 cycle: ir_we=1, pc_we=1, pc_sel=00, then go to DECODE.
- DECODE:
  - Legal op/funct goes to EXEC, except jal goes to WB and j goes to FETCH.
  - For j: pc_we=1, pc_sel=10.
  - Illegal op/funct goes to TRAP with no strobes asserted.
- EXEC:
  - addu: alu_op=00, alu_src=0, then WB.
  - subu: alu_op=01, alu_src=0, then WB.
  - ori: alu_op=10, alu_src=1, then WB.
  - lui: alu_op=11, alu_src=1, then WB.
  - lw/sw: alu_op=00, alu_src=1, then MEM.
  - beq: alu_op=01, alu_src=0; pc_we=zero, pc_sel=01; then FETCH.
  - jr: pc_we=1, pc_sel=11; then FETCH.
- MEM:
  - lw: mem_rd=1. sw: mem_wr=1.
  - Stall until mem_ready exactly as in FETCH.
  - On mem_ready=1: lw goes to WB, sw goes to FETCH.
  - mem_wr stays asserted for the whole stall. The write commits only in the ready cycle.
- WB: reg_we=1 for exactly one cycle, then FETCH.
  - addu/subu: reg_dst=00, wb_sel=00.
  - ori/lui: reg_dst=01, wb_sel=00.
  - lw: reg_dst=01, wb_sel=01.
  - jal: reg_dst=10, wb_sel=10, plus pc_we=1, pc_sel=10.
- Latency with no stalls, in cycles:
  - ALU ops 4, lw 5, sw 4, beq 3, jr 3, jal 3, j 2.
- TRAP:
  - illegal=1; all strobes held 0; remains in TRAP until reset.
- Retired counter:
  - Increments by 1 on every transition from a non-FETCH state into FETCH. TRAP never increments it.
  - Wraps modulo 2^CNT_W with no saturation.
- State encodings 6 and 7 are unreachable. If ever entered, go to FETCH on the next edge.

Test Plan:
- Directed sequence, MEM_WAIT=1, mem_ready tied 1. Run addu(000000/100001), subu(100011), ori(001101), lw(100011), sw(101011), beq(000100, zero=1), lui(001111), jal(000011), jr(000000/001000).
  -> Per-instruction cycle counts 4,4,4,5,4,3,4,3,3.
  -> retired=9.
  -> Strobes in each state exactly as listed in Behaviour.
- beq with zero=0 -> pc_we=0 in EXEC, returns to FETCH after 3 cycles, retired still increments.
- lw with mem_ready low for 3 cycles in FETCH and 2 cycles in MEM.
  -> mem_rd held high throughout each stall; ir_we pulses only in the ready cycle.
  -> Total 10 cycles; reg_we=1 for one cycle with wb_sel=01.
- Illegal encodings op=111111, and separately op=000000 with funct=000000.
  -> TRAP after DECODE, illegal=1, strobes 0 for 20 cycles, retired unchanged.
  -> Assert reset: state=0, illegal=0.
- CNT_W=4: retire 17 instructions -> retired=1 (wrap). Pulse reset mid-MEM-stall -> FETCH next cycle, retired=0.
- EN_J=1: op=000010 -> 2 cycles, pc_sel=10 in DECODE. EN_J=0: op=000010 -> TRAP.
